// File: rtl/reg_bank8_pkg.sv
// Shared constants and FSM state type for the register bank and its downstream
// 8:1 operand selector.
package reg_bank8_pkg;
   localparam int NREGS     = 8;
   localparam int AW        = 3;
   localparam int WIDTH_DEF = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;
endpackage

// File: rtl/reg_bank8.sv
// Eight-entry register bank with one synchronous write port and an eight-cycle
// sequenced clear, feeding the operand selector's in0..in7 directly.
module reg_bank8
   import reg_bank8_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             clr_req,
   output logic             busy,
   output logic             clr_done,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic [WIDTH-1:0] q2,
   output logic [WIDTH-1:0] q3,
   output logic [WIDTH-1:0] q4,
   output logic [WIDTH-1:0] q5,
   output logic [WIDTH-1:0] q6,
   output logic [WIDTH-1:0] q7
);
   state_t           r_state;
   logic [AW-1:0]    r_cnt;
   logic             r_clr_done;
   logic [WIDTH-1:0] r_regs [NREGS];
   logic             w_clear;

   assign w_clear = (r_state == CLEAR);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_clr_done <= 1'b0;
      end else begin
         r_clr_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (clr_req) begin
                  r_state <= CLEAR;
                  r_cnt   <= '0;
               end
            end
            CLEAR: begin
               // Last slot: hand back to IDLE and flag completion next cycle.
               if (r_cnt == AW'(NREGS - 1)) begin
                  r_state    <= IDLE;
                  r_cnt      <= '0;
                  r_clr_done <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + AW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Writes are only honoured in IDLE; during a sweep each register waits for its slot.
   generate
      for (genvar gi = 0; gi < NREGS; gi++) begin : g_reg
         always_ff @(posedge clk) begin
            if (rst) begin
               r_regs[gi] <= '0;
            end else if (w_clear) begin
               if (r_cnt == AW'(gi)) begin
                  r_regs[gi] <= '0;
               end
            end else if (we && (waddr == AW'(gi))) begin
               r_regs[gi] <= wdata;
            end
         end
      end
   endgenerate

   assign busy     = w_clear;
   assign clr_done = r_clr_done;
   assign q0       = r_regs[0];
   assign q1       = r_regs[1];
   assign q2       = r_regs[2];
   assign q3       = r_regs[3];
   assign q4       = r_regs[4];
   assign q5       = r_regs[5];
   assign q6       = r_regs[6];
   assign q7       = r_regs[7];
endmodule

// File: tb/tb_reg_bank8.sv
// Self-checking bench for reg_bank8: vector table, directed multi-cycle sequences
// and random traffic against a queue-based model of the clear sweep.
module tb_reg_bank8;
   logic       clk;
   logic       rst;
   logic       we;
   logic [2:0] waddr;
   logic [7:0] wdata;
   logic       clr_req;
   logic       busy;
   logic       clr_done;
   logic [7:0] dq [8];

   int tests;
   int failed;

   // Reference model: register contents plus a queue of indices still to be wiped.
   logic [7:0] m_regs [8];
   int         m_pending [$];
   logic       m_done;

   typedef struct {
      logic       we;
      logic [2:0] waddr;
      logic [7:0] wdata;
      logic       clr_req;
      logic       rst;
      logic [2:0] sel;
      logic [7:0] exp_sel;
      logic       exp_busy;
      logic       exp_done;
   } vec_t;

   vec_t vecs [26];

   reg_bank8 dut (
      .clk      (clk),
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .wdata    (wdata),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_done (clr_done),
      .q0       (dq[0]),
      .q1       (dq[1]),
      .q2       (dq[2]),
      .q3       (dq[3]),
      .q4       (dq[4]),
      .q5       (dq[5]),
      .q6       (dq[6]),
      .q7       (dq[7])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic model_edge(input logic i_we, input logic [2:0] a, input logic [7:0] d,
                             input logic c, input logic r);
      int idx;
      if (r) begin
         for (int k = 0; k < 8; k++) m_regs[k] = 8'h00;
         m_pending.delete();
         m_done = 1'b0;
      end else begin
         m_done = 1'b0;
         if (m_pending.size() != 0) begin
            idx = m_pending.pop_front();
            m_regs[idx] = 8'h00;
            if (m_pending.size() == 0) m_done = 1'b1;
         end else begin
            if (i_we) m_regs[a] = d;
            if (c) for (int k = 0; k < 8; k++) m_pending.push_back(k);
         end
      end
   endtask

   task automatic check_model();
      check("busy", {31'b0, busy}, {31'b0, m_pending.size() != 0});
      check("clr_done", {31'b0, clr_done}, {31'b0, m_done});
      for (int k = 0; k < 8; k++)
         check($sformatf("q%0d", k), {24'b0, dq[k]}, {24'b0, m_regs[k]});
   endtask

   // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
   task automatic cycle(input logic i_we, input logic [2:0] a, input logic [7:0] d,
                        input logic c, input logic r);
      we = i_we; waddr = a; wdata = d; clr_req = c; rst = r;
      @(posedge clk);
      model_edge(i_we, a, d, c, r);
      #1;
      check_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      int busy_cnt;
      int done_cnt;
      int hold_cnt;
      logic [7:0] v;

      tests = 0;
      failed = 0;
      we = 1'b0; waddr = '0; wdata = '0; clr_req = 1'b0; rst = 1'b1;
      for (int k = 0; k < 8; k++) m_regs[k] = 8'h00;
      m_done = 1'b0;

      // Reset after arbitrary writes.
      cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
      cycle(1'b1, 3'd2, 8'h3C, 1'b0, 1'b0);
      cycle(1'b1, 3'd6, 8'hC3, 1'b0, 1'b0);
      cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
      cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
      for (int k = 0; k < 8; k++) check($sformatf("rst_q%0d", k), {24'b0, dq[k]}, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      check("rst_done", {31'b0, clr_done}, 32'h0);

      // Table: write sweep, selector read-back, then a clear of those values.
      for (int k = 0; k < 8; k++) begin
         v = 8'(8'h11 * (k + 1));
         vecs[k]     = '{1'b1, 3'(k), v, 1'b0, 1'b0, 3'(k), v, 1'b0, 1'b0};
         vecs[8 + k] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'(k), v, 1'b0, 1'b0};
         vecs[17 + k] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'(k), 8'h00, (k < 7), (k == 7)};
      end
      vecs[16] = '{1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd7, 8'h88, 1'b1, 1'b0};
      vecs[25] = '{1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd7, 8'h00, 1'b0, 1'b0};
      for (int i = 0; i < 26; i++) begin
         cycle(vecs[i].we, vecs[i].waddr, vecs[i].wdata, vecs[i].clr_req, vecs[i].rst);
         check($sformatf("tbl%0d_sel", i), {24'b0, dq[vecs[i].sel]}, {24'b0, vecs[i].exp_sel});
         check($sformatf("tbl%0d_busy", i), {31'b0, busy}, {31'b0, vecs[i].exp_busy});
         check($sformatf("tbl%0d_done", i), {31'b0, clr_done}, {31'b0, vecs[i].exp_done});
      end

      // Clear of an all-0xFF bank: ordered fall, 8 busy cycles, one done pulse.
      for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), 8'hFF, 1'b0, 1'b0);
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
      busy_cnt = 0;
      done_cnt = 0;
      if (busy) busy_cnt++;
      for (int j = 0; j < 12; j++) begin
         cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
         if (busy) busy_cnt++;
         if (clr_done) done_cnt++;
         if (j < 7) begin
            check($sformatf("ff_cleared%0d", j), {24'b0, dq[j]}, 32'h0);
            check($sformatf("ff_kept%0d", j + 1), {24'b0, dq[j + 1]}, 32'hFF);
         end
         if (j == 7) check("ff_done_after_busy", {30'b0, clr_done, busy}, 32'h2);
      end
      check("ff_busy_cycles", busy_cnt, 8);
      check("ff_done_pulses", done_cnt, 1);

      // Collision: write with clr_req survives until slot 3; write during CLEAR dropped.
      for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), 8'h77, 1'b0, 1'b0);
      cycle(1'b1, 3'd3, 8'hA5, 1'b1, 1'b0);
      hold_cnt = (dq[3] == 8'hA5) ? 1 : 0;
      cycle(1'b1, 3'd7, 8'h5A, 1'b0, 1'b0);
      if (dq[3] == 8'hA5) hold_cnt++;
      check("drop_q7_untouched", {24'b0, dq[7]}, 32'h77);
      for (int j = 0; j < 8; j++) begin
         cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
         if (dq[3] == 8'hA5) hold_cnt++;
      end
      check("coll_q3_hold", hold_cnt, 4);
      check("drop_q7_final", {24'b0, dq[7]}, 32'h0);

      // Reset asserted in the 4th busy cycle aborts the sweep with no done pulse.
      for (int k = 0; k < 8; k++) cycle(1'b1, 3'(k), 8'hE0 + 8'(k), 1'b0, 1'b0);
      cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
      idle(3);
      check("mid_busy_before", {31'b0, busy}, 32'h1);
      check("mid_q5_before", {24'b0, dq[5]}, 32'hE5);
      cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b1);
      check("mid_busy", {31'b0, busy}, 32'h0);
      check("mid_q5", {24'b0, dq[5]}, 32'h0);
      done_cnt = 0;
      for (int j = 0; j < 10; j++) begin
         cycle(1'b0, 3'd0, 8'h00, 1'b0, 1'b0);
         if (clr_done) done_cnt++;
      end
      check("mid_no_done", done_cnt, 0);

      // clr_req held 20 cycles: busy x8, done, busy x8, done, then a third start.
      busy_cnt = 0;
      done_cnt = 0;
      for (int j = 0; j < 20; j++) begin
         cycle(1'b0, 3'd0, 8'h00, 1'b1, 1'b0);
         if (j < 18) begin
            check($sformatf("hold%0d_busy", j), {31'b0, busy}, {31'b0, (j != 8) && (j != 17)});
            check($sformatf("hold%0d_done", j), {31'b0, clr_done}, {31'b0, (j == 8) || (j == 17)});
         end
         if (busy && clr_done) busy_cnt++;
         if (clr_done) done_cnt++;
      end
      check("hold_done_pulses", done_cnt, 2);
      check("hold_overlap", busy_cnt, 0);
      idle(10);
      check("hold_settled", {31'b0, busy}, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         cycle(($urandom_range(0, 1) == 1), 3'($urandom_range(0, 7)), 8'($urandom),
               ($urandom_range(0, 11) == 0), ($urandom_range(0, 79) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
